// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative unsigned MULTU/DIVU sequencer driving the shared ALU, holds HI/LO
module alu_muldiv_seq #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] OP_ADD  = 3'b010,
  parameter logic [2:0] OP_SUB  = 3'b011,
  parameter logic [2:0] OP_IDLE = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state;
  logic             op_div;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;

  // Partial remainder for this divide step: HI shifted left, next dividend bit in.
  logic [WIDTH-1:0] rs;
  logic             ge;
  logic             carry;

  assign rs    = {hi[WIDTH-2:0], lo[WIDTH-1]};
  // The bit shifted out of HI makes the 33-bit remainder at least 2^WIDTH > M.
  assign ge    = hi[WIDTH-1] | (rs >= m);
  // Carry out of hi + M, recovered without widening the ALU.
  assign carry = (alu_result < hi);

  // ALU request for the current step; idle (AND of zeros) whenever no add/sub is needed.
  always_comb begin
    alu_op = OP_IDLE;
    alu_a  = '0;
    alu_b  = '0;
    if (state == S_CALC) begin
      if (op_div) begin
        alu_op = OP_SUB;
        alu_a  = rs;
        alu_b  = m;
      end else if (lo[0]) begin
        alu_op = OP_ADD;
        alu_a  = hi;
        alu_b  = m;
      end
    end
  end

  // Sequencer FSM with HI/LO/M datapath registers and registered busy/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      op_div <= 1'b0;
      m      <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_div <= md_op;
            hi     <= '0;
            lo     <= md_op ? src_a : src_b;
            m      <= md_op ? src_b : src_a;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_CALC;
          end else begin
            if (mt_hi) hi <= src_a;
            if (mt_lo) lo <= src_a;
          end
        end
        S_CALC: begin
          if (op_div) begin
            hi <= ge ? alu_result : rs;
            lo <= {lo[WIDTH-2:0], ge};
          end else if (lo[0]) begin
            {hi, lo} <= {carry, alu_result, lo[WIDTH-1:1]};
          end else begin
            {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed self-checking bench for alu_muldiv_seq
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         md_op = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         mt_hi = 1'b0;
  logic         mt_lo = 1'b0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors = 0;
  int errors  = 0;

  // Cycle statistics gathered by wait_done for the calling test to compare.
  int cyc_to_done;
  int busy_cycles;
  int add_cycles;

  always #5 clk = ~clk;

  // Reference ALU: AND / ADD / SUB.
  always_comb begin
    case (alu_op)
      3'b010:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = alu_a - alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  alu_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .mt_hi(mt_hi), .mt_lo(mt_lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Drive a one-cycle start; returns at the negedge after the accepting edge.
  task automatic launch(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from the accepting edge until done, bounded at 100.
  task automatic wait_done();
    cyc_to_done = 1;
    busy_cycles = 0;
    add_cycles  = 0;
    while (!done && cyc_to_done < 100) begin
      if (busy) busy_cycles++;
      if (busy && alu_op === 3'b010) add_cycles++;
      @(negedge clk);
      cyc_to_done++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({hi, lo, busy, done, alu_op, alu_a, alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b op=%b a=%h b=%h required all zero",
               hi, lo, busy, done, alu_op, alu_a, alu_b);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mt();
    @(negedge clk);
    mt_hi = 1'b1; src_a = 32'h1234_5678;
    @(negedge clk);
    mt_hi = 1'b0; mt_lo = 1'b1; src_a = 32'h9abc_def0;
    @(negedge clk);
    mt_lo = 1'b0;
    vectors++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9abc_def0) begin
      errors++;
      $display("FAIL mt_single: hi=%h lo=%h required 12345678 9abcdef0", hi, lo);
    end
    mt_hi = 1'b1; mt_lo = 1'b1; src_a = 32'h0bad_cafe;
    @(negedge clk);
    mt_hi = 1'b0; mt_lo = 1'b0;
    vectors++;
    if (hi !== 32'h0bad_cafe || lo !== 32'h0bad_cafe) begin
      errors++;
      $display("FAIL mt_both: hi=%h lo=%h required 0badcafe 0badcafe", hi, lo);
    end
  endtask

  task automatic test_mul_small();
    launch(1'b0, 32'd7, 32'd6);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy_start: busy=%b done=%b required 1 0", busy, done);
    end
    wait_done();
    vectors++;
    if (cyc_to_done !== 33 || busy_cycles !== 32) begin
      errors++;
      $display("FAIL mul_latency: done_at=%0d busy=%0d required 33 32", cyc_to_done, busy_cycles);
    end
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL mul_7x6: hi=%h lo=%h required 00000000 0000002a", hi, lo);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL mul_hold: done=%b hi=%h lo=%h required 0 0 2a", done, hi, lo);
    end
  endtask

  task automatic test_mul_max();
    launch(1'b0, 32'hffff_ffff, 32'hffff_ffff);
    wait_done();
    vectors++;
    if (hi !== 32'hffff_fffe || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL mul_max: hi=%h lo=%h required fffffffe 00000001", hi, lo);
    end
    vectors++;
    if (add_cycles !== 32) begin
      errors++;
      $display("FAIL mul_max_aluop: add steps=%0d required 32", add_cycles);
    end
  endtask

  task automatic test_div();
    launch(1'b1, 32'd100, 32'd7);
    vectors++;
    if (alu_op !== 3'b011) begin
      errors++;
      $display("FAIL div_aluop: op=%b required 011", alu_op);
    end
    wait_done();
    vectors++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL div_100_7: lo=%h hi=%h required 0000000e 00000002", lo, hi);
    end
    launch(1'b1, 32'h8000_0000, 32'd3);
    wait_done();
    vectors++;
    if (lo !== 32'h2aaa_aaaa || hi !== 32'd2) begin
      errors++;
      $display("FAIL div_msb_3: lo=%h hi=%h required 2aaaaaaa 00000002", lo, hi);
    end
    launch(1'b1, 32'hffff_ffff, 32'hffff_ffff);
    wait_done();
    vectors++;
    if (lo !== 32'd1 || hi !== 32'd0) begin
      errors++;
      $display("FAIL div_max_max: lo=%h hi=%h required 00000001 00000000", lo, hi);
    end
  endtask

  task automatic test_div_zero();
    launch(1'b1, 32'd5, 32'd0);
    wait_done();
    vectors++;
    if (cyc_to_done !== 33) begin
      errors++;
      $display("FAIL div0_latency: done_at=%0d required 33", cyc_to_done);
    end
    vectors++;
    if (lo !== 32'hffff_ffff || hi !== 32'd5) begin
      errors++;
      $display("FAIL div0_result: lo=%h hi=%h required ffffffff 00000005", lo, hi);
    end
  endtask

  task automatic test_ignored_inputs();
    launch(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    start = 1'b1; mt_lo = 1'b1; mt_hi = 1'b1; md_op = 1'b1; src_a = 32'hdead_beef; src_b = 32'd1;
    @(negedge clk);
    start = 1'b0; mt_lo = 1'b0; mt_hi = 1'b0;
    wait_done();
    vectors++;
    if (cyc_to_done !== 23 || hi !== 32'd0 || lo !== 32'd3000) begin
      errors++;
      $display("FAIL busy_ignore: done_at=%0d hi=%h lo=%h required 23 0 00000bb8",
               cyc_to_done, hi, lo);
    end
    // Same-cycle start and mt_hi: the operation wins and HI is not written.
    @(negedge clk);
    start = 1'b1; mt_hi = 1'b1; md_op = 1'b0; src_a = 32'd9; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0; mt_hi = 1'b0;
    vectors++;
    if (busy !== 1'b1 || hi !== 32'd0) begin
      errors++;
      $display("FAIL start_vs_mt: busy=%b hi=%h required 1 00000000", busy, hi);
    end
    wait_done();
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd45) begin
      errors++;
      $display("FAIL start_vs_mt_result: hi=%h lo=%h required 0 0000002d", hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    launch(1'b0, 32'hffff_ffff, 32'hffff_ffff);
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || alu_op !== 3'b000) begin
      errors++;
      $display("FAIL reset_abort: hi=%h lo=%h busy=%b op=%b required 0 0 0 000",
               hi, lo, busy, alu_op);
    end
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_idle: busy=%b done=%b required 0 0", busy, done);
    end
    launch(1'b1, 32'd1000, 32'd33);
    wait_done();
    vectors++;
    if (lo !== 32'd30 || hi !== 32'd10) begin
      errors++;
      $display("FAIL after_reset_div: lo=%h hi=%h required 0000001e 0000000a", lo, hi);
    end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mul_small();
    test_mul_max();
    test_div();
    test_div_zero();
    test_ignored_inputs();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
